// File: rtl/gray_decoder.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : gray_decoder
// Description : Samples a Gray-coded count from an upstream counter, decodes
//               it to binary and checks that successive samples follow the
//               legal +1 Gray sequence. Reports the decoded value, forward
//               wrap events and sequence errors through an
//               UNSYNC / TRACK / ERROR state machine.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters:
//   WIDTH      Gray/binary code width in bits (2..8)
// Optional feature macro:
//   GRAY_DEC_BIDIR_EN  accept -1 steps in TRACK and report them on Dir
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   synchronous, active-high reset
//   In_valid   in   Gray_in is sampled this cycle
//   Gray_in    in   Gray-coded count [WIDTH-1:0]
//   Clear_err  in   return to UNSYNC, clear Seq_err/Wrap/Wrap_cnt
//   Bin_out    out  binary decode of the last accepted sample
//   Out_valid  out  one-cycle pulse per accepted sample
//   Locked     out  high while in TRACK
//   Wrap       out  sticky forward-wrap flag
//   Wrap_cnt   out  forward wrap count, saturating at 255
//   Seq_err    out  sticky illegal-transition flag
//   Dir        out  1 when the last accepted step was -1 (0 without BIDIR)
//----------------------------------------------------------------------------
module gray_decoder #(
   parameter int WIDTH = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             In_valid,
   input  logic [WIDTH-1:0] Gray_in,
   input  logic             Clear_err,
   output logic [WIDTH-1:0] Bin_out,
   output logic             Out_valid,
   output logic             Locked,
   output logic             Wrap,
   output logic [7:0]       Wrap_cnt,
   output logic             Seq_err,
   output logic             Dir
);

   localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'd0,
      ST_TRACK  = 2'd1,
      ST_ERROR  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_bin;
   logic             r_out_valid;
   logic             r_locked;
   logic             r_wrap;
   logic [7:0]       r_wrap_cnt;
   logic             r_seq_err;

   logic [WIDTH-1:0] w_bin_new;
   logic [WIDTH-1:0] w_step;

   // Binary bit i is the XOR of all Gray bits from the MSB down to bit i.
   always_comb begin
      w_bin_new = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_bin_new[i] = ^(Gray_in >> i);
      end
   end

   // Modular step from the last accepted value; wraps naturally in WIDTH bits.
   assign w_step = w_bin_new - r_bin;

`ifdef GRAY_DEC_BIDIR_EN
   logic r_dir;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= ST_UNSYNC;
         r_bin       <= '0;
         r_out_valid <= 1'b0;
         r_locked    <= 1'b0;
         r_wrap      <= 1'b0;
         r_wrap_cnt  <= 8'd0;
         r_seq_err   <= 1'b0;
`ifdef GRAY_DEC_BIDIR_EN
         r_dir       <= 1'b0;
`endif
      end else begin
         r_out_valid <= 1'b0;
         if (Clear_err) begin
            // Clear wins over a coincident sample, which is dropped.
            r_state    <= ST_UNSYNC;
            r_locked   <= 1'b0;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= 8'd0;
            r_seq_err  <= 1'b0;
         end else if (In_valid) begin
            case (r_state)
               ST_UNSYNC: begin
                  r_bin       <= w_bin_new;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_TRACK;
                  r_locked    <= 1'b1;
               end
               ST_TRACK: begin
                  if (w_step == '0) begin
                     r_out_valid <= 1'b1;
                  end else if (w_step == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                     r_bin       <= w_bin_new;
                     r_out_valid <= 1'b1;
`ifdef GRAY_DEC_BIDIR_EN
                     r_dir       <= 1'b0;
`endif
                     // A +1 step from the top value is necessarily a wrap to 0.
                     if (r_bin == C_MAX) begin
                        r_wrap <= 1'b1;
                        if (r_wrap_cnt != 8'hFF) begin
                           r_wrap_cnt <= r_wrap_cnt + 8'd1;
                        end
                     end
`ifdef GRAY_DEC_BIDIR_EN
                  end else if (w_step == C_MAX) begin
                     // Backward step: backward wraps are not counted.
                     r_bin       <= w_bin_new;
                     r_out_valid <= 1'b1;
                     r_dir       <= 1'b1;
`endif
                  end else begin
                     r_seq_err <= 1'b1;
                     r_state   <= ST_ERROR;
                     r_locked  <= 1'b0;
                  end
               end
               ST_ERROR: begin
                  // Samples are ignored until Clear_err.
               end
               default: begin
                  r_state  <= ST_UNSYNC;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Bin_out   = r_bin;
   assign Out_valid = r_out_valid;
   assign Locked    = r_locked;
   assign Wrap      = r_wrap;
   assign Wrap_cnt  = r_wrap_cnt;
   assign Seq_err   = r_seq_err;
`ifdef GRAY_DEC_BIDIR_EN
   assign Dir       = r_dir;
`else
   assign Dir       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_decoder.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : tb_gray_decoder
// Description : Self-checking bench for gray_decoder. Stimulus is chosen as
//               binary counts and Gray-encoded (g = b ^ (b >> 1)); a
//               behavioural model tracks the expected outputs from the
//               mode / last-value / step rules using plain integers.
//               Honours GRAY_DEC_BIDIR_EN when compiled with it.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_gray_decoder;

   localparam int WIDTH = 3;
   localparam int NVAL  = 1 << WIDTH;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             In_valid;
   logic [WIDTH-1:0] Gray_in;
   logic             Clear_err;
   logic [WIDTH-1:0] Bin_out;
   logic             Out_valid;
   logic             Locked;
   logic             Wrap;
   logic [7:0]       Wrap_cnt;
   logic             Seq_err;
   logic             Dir;

   gray_decoder #(.WIDTH(WIDTH)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .In_valid  (In_valid),
      .Gray_in   (Gray_in),
      .Clear_err (Clear_err),
      .Bin_out   (Bin_out),
      .Out_valid (Out_valid),
      .Locked    (Locked),
      .Wrap      (Wrap),
      .Wrap_cnt  (Wrap_cnt),
      .Seq_err   (Seq_err),
      .Dir       (Dir)
   );

   always #5 Clk = ~Clk;

`ifdef GRAY_DEC_BIDIR_EN
   localparam bit BIDIR = 1'b1;
`else
   localparam bit BIDIR = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural reference: mode 0 = waiting for first sample,
   // 1 = following the count, 2 = stopped on an error.
   int m_mode, m_bin, m_cnt;
   bit m_ov, m_wrap, m_err, m_dir;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_bin = 0; m_cnt = 0;
      m_ov = 0; m_wrap = 0; m_err = 0; m_dir = 0;
   endtask

   task automatic model_step(input bit rst, input bit v, input int b, input bit clr);
      int d;
      if (rst) begin
         model_reset();
         return;
      end
      m_ov = 0;
      if (clr) begin
         m_mode = 0; m_err = 0; m_wrap = 0; m_cnt = 0;
      end else if (v) begin
         if (m_mode == 0) begin
            m_bin = b; m_ov = 1; m_mode = 1;
         end else if (m_mode == 1) begin
            d = (b - m_bin + NVAL) % NVAL;
            if (d == 0) begin
               m_ov = 1;
            end else if (d == 1) begin
               if (m_bin == NVAL - 1) begin
                  m_wrap = 1;
                  if (m_cnt < 255) m_cnt = m_cnt + 1;
               end
               m_bin = b; m_ov = 1; m_dir = 0;
            end else if (BIDIR && d == NVAL - 1) begin
               m_bin = b; m_ov = 1; m_dir = 1;
            end else begin
               m_err = 1; m_mode = 2;
            end
         end
      end
   endtask

   // One clock: drive at negedge, advance model at posedge, compare after it.
   task automatic step(input bit rst, input bit v, input int b, input bit clr);
      @(negedge Clk);
      Reset     = rst;
      In_valid  = v;
      Clear_err = clr;
      Gray_in   = WIDTH'(b ^ (b >> 1));
      @(posedge Clk);
      model_step(rst, v, b, clr);
      #1;
      check("bin_out",   int'(Bin_out),   m_bin);
      check("out_valid", int'(Out_valid), int'(m_ov));
      check("locked",    int'(Locked),    (m_mode == 1) ? 1 : 0);
      check("wrap",      int'(Wrap),      int'(m_wrap));
      check("wrap_cnt",  int'(Wrap_cnt),  m_cnt);
      check("seq_err",   int'(Seq_err),   int'(m_err));
      check("dir",       int'(Dir),       int'(m_dir));
   endtask

   initial begin
      int b, r;
      Reset = 1'b1; In_valid = 1'b0; Clear_err = 1'b0; Gray_in = '0;
      model_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("reset_bin", int'(Bin_out), 0);
      check("reset_locked", int'(Locked), 0);

      // Full forward sequence 0..7, then wrap to 0.
      for (int i = 0; i < NVAL; i++) step(0, 1, i, 0);
      check("seq_bin7", int'(Bin_out), 7);
      step(0, 1, 0, 0);
      check("wrap_first", int'(Wrap), 1);
      check("wrap_cnt_first", int'(Wrap_cnt), 1);

      // 300 more full cycles drive the counter into saturation.
      for (int c = 0; c < 300; c++)
         for (int i = 1; i <= NVAL; i++) step(0, 1, i % NVAL, 0);
      check("wrap_cnt_sat", int'(Wrap_cnt), 255);

      // Illegal jump 2 -> 5.
      step(0, 1, 1, 0);
      step(0, 1, 2, 0);
      step(0, 1, 5, 0);
      check("err_set", int'(Seq_err), 1);
      check("err_bin_hold", int'(Bin_out), 2);
      step(0, 1, 3, 0);
      step(0, 1, 4, 0);
      step(0, 0, 0, 1);
      check("clr_cnt", int'(Wrap_cnt), 0);
      step(0, 1, 2, 0);
      check("relock", int'(Locked), 1);

      // Repeats, then a -1 step from 3.
      for (int i = 0; i < 3; i++) step(0, 1, 2, 0);
      step(0, 1, 3, 0);
      step(0, 1, 2, 0);
      check("minus1_err", int'(Seq_err), BIDIR ? 0 : 1);

      // Clear and sample on the same edge: sample is dropped.
      step(0, 0, 0, 1);
      step(0, 1, 4, 0);
      step(0, 1, 5, 1);
      check("clr_wins_ov", int'(Out_valid), 0);
      step(0, 1, 6, 0);
      step(0, 1, 7, 0);
      step(1, 1, 0, 1);
      check("midreset_bin", int'(Bin_out), 0);

      // Randomized phase, biased towards legal steps.
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      b = (m_bin + 1) % NVAL;
         else if (r < 60) b = m_bin;
         else if (r < 75) b = (m_bin + NVAL - 1) % NVAL;
         else             b = $urandom_range(0, NVAL - 1);
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 3) != 0),
              b,
              ($urandom_range(0, 24) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
